// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the instruction sequencer and processor control logic.
package instr_sequencer_pkg;

  localparam int unsigned INSTR_WIDTH_DEF = 9;
  localparam int unsigned ADDR_WIDTH_DEF  = 4;
  localparam int unsigned WATCHDOG_DEF    = 4;
  localparam int unsigned OPCODE_W        = 3;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned STATE_W         = 3;

  // Processor opcodes, carried in the top three bits of an instruction word
  localparam logic [OPCODE_W-1:0] OP_MV  = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_MVI = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_SUB = 3'b011;

  // Sequencer state encoding
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] ST_IMM   = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd3;
  localparam logic [STATE_W-1:0] ST_HALT  = 3'd4;
  localparam logic [STATE_W-1:0] ST_ERR   = 3'd5;

  // Increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // States in which an instruction is in flight
  function automatic logic is_busy(input logic [STATE_W-1:0] s);
    return (s == ST_FETCH) || (s == ST_IMM) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control, program-load and processor-side signals of the instruction sequencer.
interface instr_sequencer_if
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned IW = INSTR_WIDTH_DEF,
  parameter int unsigned AW = ADDR_WIDTH_DEF
) ();

  logic                start;
  logic [AW:0]         prog_len;
  logic                ld_en;
  logic [AW-1:0]       ld_addr;
  logic [IW-1:0]       ld_data;
  logic                done;
  logic [IW-1:0]       din;
  logic                run;
  logic                busy;
  logic                halted;
  logic                error;
  logic [AW:0]         pc;
  logic [CNT_W-1:0]    instr_cnt;
  logic [OPCODE_W-1:0] opcode;

  modport master (
    output start, prog_len, ld_en, ld_addr, ld_data, done,
    input  din, run, busy, halted, error, pc, instr_cnt, opcode
  );

  modport slave (
    input  start, prog_len, ld_en, ld_addr, ld_data, done,
    output din, run, busy, halted, error, pc, instr_cnt, opcode
  );

endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program memory: one synchronous write port, one asynchronous read port, no reset.
module prog_mem #(
  parameter int unsigned WIDTH      = 9,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Steps through program memory, handing instructions and immediates to the processor.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH        = ADDR_WIDTH_DEF,
  parameter int unsigned WATCHDOG          = WATCHDOG_DEF
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.slave bus
);

  localparam int unsigned PC_W = ADDR_WIDTH + 1;
  localparam int unsigned WD_W = $clog2(WATCHDOG + 1);

  logic [STATE_W-1:0]           state_q, state_n;
  logic [PC_W-1:0]              pc_q, pc_n, pc_inc;
  logic [CNT_W-1:0]             cnt_q, cnt_n;
  logic [WD_W-1:0]              wd_q, wd_n;
  logic [OPCODE_W-1:0]          opcode_q, opcode_n;
  logic                         run_q, busy_q, halted_q, error_q;
  logic                         mem_we;
  logic [INSTRUCTION_WIDTH-1:0] mem_rdata;
  logic [OPCODE_W-1:0]          fetch_op;

  prog_mem #(
    .WIDTH      (INSTRUCTION_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.ld_addr),
    .wdata (bus.ld_data),
    .raddr (pc_q[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  assign pc_inc   = pc_q + PC_W'(1);
  assign fetch_op = mem_rdata[INSTRUCTION_WIDTH-1 -: OPCODE_W];

  // State and datapath registers; status flags are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
      opcode_q <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      cnt_q    <= cnt_n;
      wd_q     <= wd_n;
      opcode_q <= opcode_n;
      run_q    <= (state_n == ST_FETCH);
      busy_q   <= is_busy(state_n);
      halted_q <= (state_n == ST_HALT);
      error_q  <= (state_n == ST_ERR);
    end
  end

  // Next-state, program counter, counters and load-port gating
  always_comb begin
    state_n  = state_q;
    pc_n     = pc_q;
    cnt_n    = cnt_q;
    wd_n     = wd_q;
    opcode_n = opcode_q;
    mem_we   = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT, ST_ERR: begin
        mem_we = bus.ld_en;
        if (bus.start) begin
          pc_n    = '0;
          cnt_n   = '0;
          wd_n    = '0;
          state_n = (bus.prog_len == '0) ? ST_HALT : ST_FETCH;
        end
      end

      ST_FETCH: begin
        opcode_n = fetch_op;
        pc_n     = pc_inc;
        wd_n     = '0;
        if (fetch_op == OP_MVI) begin
          // an mvi in the last slot has no immediate to follow it
          state_n = (pc_inc == bus.prog_len) ? ST_ERR : ST_IMM;
        end else begin
          state_n = ST_WAIT;
        end
      end

      ST_IMM: begin
        if (bus.done) begin
          pc_n    = pc_inc;
          cnt_n   = sat_inc(cnt_q);
          state_n = (pc_inc >= bus.prog_len) ? ST_HALT : ST_FETCH;
        end else begin
          state_n = ST_ERR;
        end
      end

      ST_WAIT: begin
        if (bus.done) begin
          cnt_n   = sat_inc(cnt_q);
          wd_n    = '0;
          state_n = (pc_q >= bus.prog_len) ? ST_HALT : ST_FETCH;
        end else begin
          wd_n = wd_q + WD_W'(1);
          if (wd_n == WD_W'(WATCHDOG)) state_n = ST_ERR;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // Memory word is only shown to the processor while fetching an opcode or immediate
  assign bus.din       = ((state_q == ST_FETCH) || (state_q == ST_IMM)) ? mem_rdata : '0;
  assign bus.run       = run_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.error     = error_q;
  assign bus.pc        = pc_q;
  assign bus.instr_cnt = cnt_q;
  assign bus.opcode    = opcode_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs, monitor checks din/run and end status.
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  instr_sequencer_if #(.IW(9), .AW(4)) bus ();

  instr_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_end;
    logic [8:0] din;
    logic       run;
    logic       halted;
    logic       error;
    logic [4:0] pc;
    logic [7:0] cnt;
    int         t;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_din(input logic [8:0] d, input logic r, input int t);
    exp_t e;
    e = '{is_end: 1'b0, din: d, run: r, halted: 1'b0, error: 1'b0, pc: 5'd0, cnt: 8'd0, t: t};
    q.push_back(e);
  endfunction

  function automatic void push_end(input logic h, input logic er, input logic [4:0] pc,
                                   input logic [7:0] cnt, input int t);
    exp_t e;
    e = '{is_end: 1'b1, din: 9'h000, run: 1'b0, halted: h, error: er, pc: pc, cnt: cnt, t: t};
    q.push_back(e);
  endfunction

  // Monitor: cycle index t counts edges since the edge that accepted start
  initial begin : monitor
    int   t;
    logic h_prev, e_prev;
    exp_t e;
    t = 0;
    h_prev = 1'b0;
    e_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.start) t = 0;
      else t++;
      if (bus.din !== 9'h000) begin
        if (q.size() == 0) begin
          chk("unexpected_din", 32'(bus.din), 32'h0);
        end else begin
          e = q.pop_front();
          chk("rec_kind_din", 32'(e.is_end), 32'(1'b0));
          chk("din", 32'(bus.din), 32'(e.din));
          chk("run_with_din", 32'(bus.run), 32'(e.run));
          chk("din_cycle", 32'(t), 32'(e.t));
        end
      end else begin
        chk("run_without_din", 32'(bus.run), 32'(1'b0));
      end
      if ((bus.halted === 1'b1 && !h_prev) || (bus.error === 1'b1 && !e_prev)) begin
        if (q.size() == 0) begin
          chk("unexpected_end", 32'({bus.halted, bus.error}), 32'h0);
        end else begin
          e = q.pop_front();
          chk("rec_kind_end", 32'(e.is_end), 32'(1'b1));
          chk("halted", 32'(bus.halted), 32'(e.halted));
          chk("error", 32'(bus.error), 32'(e.error));
          chk("pc", 32'(bus.pc), 32'(e.pc));
          chk("instr_cnt", 32'(bus.instr_cnt), 32'(e.cnt));
          chk("busy_at_end", 32'(bus.busy), 32'(1'b0));
          chk("end_cycle", 32'(t), 32'(e.t));
        end
      end
      h_prev = bus.halted;
      e_prev = bus.error;
    end
  end

  task automatic load(input logic [3:0] a, input logic [8:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] len);
    bus.prog_len = len;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_din"},    32'(bus.din),       32'h0);
    chk({tag, "_run"},    32'(bus.run),       32'h0);
    chk({tag, "_busy"},   32'(bus.busy),      32'h0);
    chk({tag, "_halted"}, 32'(bus.halted),    32'h0);
    chk({tag, "_error"},  32'(bus.error),     32'h0);
    chk({tag, "_pc"},     32'(bus.pc),        32'h0);
    chk({tag, "_cnt"},    32'(bus.instr_cnt), 32'h0);
  endtask

  initial begin : stim
    bus.start    = 1'b0;
    bus.prog_len = '0;
    bus.ld_en    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.done     = 1'b0;
    #1 rst = 1'b1;
    #2 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // mvi r0,#5 with done held high (ignored in FETCH, consumed in IMM)
    load(4'd0, 9'h040);
    load(4'd1, 9'h005);
    push_din(9'h040, 1'b1, 0);
    push_din(9'h005, 1'b0, 1);
    push_end(1'b1, 1'b0, 5'd2, 8'd1, 2);
    bus.done = 1'b1;
    pulse_start(5'd2);
    repeat (4) @(negedge clk);
    bus.done = 1'b0;

    // add r1,r0 completing on the third WAIT cycle
    load(4'd0, 9'h088);
    push_din(9'h088, 1'b1, 0);
    push_end(1'b1, 1'b0, 5'd1, 8'd1, 4);
    pulse_start(5'd1);
    repeat (3) @(negedge clk);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    repeat (2) @(negedge clk);

    // mv with no done: watchdog trips after four WAIT cycles
    load(4'd0, 9'h008);
    push_din(9'h008, 1'b1, 0);
    push_end(1'b0, 1'b1, 5'd1, 8'd0, 5);
    pulse_start(5'd1);
    repeat (7) @(negedge clk);

    // mvi in the last slot: straight to ERR, no IMM cycle
    load(4'd0, 9'h040);
    push_din(9'h040, 1'b1, 0);
    push_end(1'b0, 1'b1, 5'd1, 8'd0, 1);
    pulse_start(5'd1);
    repeat (3) @(negedge clk);

    // empty program from ERR: HALT next cycle, error cleared, run stays low
    push_end(1'b1, 1'b0, 5'd0, 8'd0, 0);
    pulse_start(5'd0);
    repeat (3) @(negedge clk);

    // start with a same-cycle write to word 0, busy write ignored, reset in WAIT
    load(4'd0, 9'h088);
    load(4'd1, 9'h005);
    load(4'd2, 9'h088);
    push_din(9'h040, 1'b1, 0);
    push_din(9'h005, 1'b0, 1);
    push_din(9'h088, 1'b1, 2);
    bus.ld_en    = 1'b1;
    bus.ld_addr  = 4'd0;
    bus.ld_data  = 9'h040;
    bus.prog_len = 5'd3;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    bus.done  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.done    = 1'b0;
    bus.ld_en   = 1'b1;
    bus.ld_addr = 4'd1;
    bus.ld_data = 9'h1AA;
    @(negedge clk);
    bus.ld_en = 1'b0;
    chk("busy_in_wait", 32'(bus.busy), 32'h1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // rerun of the mvi program: memory survived reset and the busy write
    push_din(9'h040, 1'b1, 0);
    push_din(9'h005, 1'b0, 1);
    push_end(1'b1, 1'b0, 5'd2, 8'd1, 2);
    bus.done = 1'b1;
    pulse_start(5'd2);
    repeat (4) @(negedge clk);
    bus.done = 1'b0;

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
